// File: rtl/keypad_scan_ctrl.sv
// Keypad matrix scanner: drives one column at a time, samples the synchronized rows,
// debounces whole frames and hands single-key press codes to a one-deep output buffer.
module keypad_scan_ctrl #(
   parameter int ROWS           = 4,
   parameter int COLS           = 4,
   parameter int SETTLE_CYC     = 8,
   parameter int DEBOUNCE_SCANS = 4,
   parameter int CODE_W         = $clog2(ROWS*COLS)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ROWS-1:0]   rows_in,
   output logic [COLS-1:0]   col_out,
   output logic              key_valid,
   output logic [CODE_W-1:0] key_code,
   input  logic              key_ready,
   output logic              key_pressed,
   output logic              overflow,
   input  logic              clear_ovf
);

   localparam int N     = ROWS * COLS;
   localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
   localparam int CNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
   localparam int STB_W = $clog2(DEBOUNCE_SCANS + 1);

   typedef enum logic {SETTLE, EVAL} state_t;

   state_t            state_reg, state_next;
   logic [ROWS-1:0]   rows_meta_reg, rows_sync_reg;
   logic [COL_W-1:0]  col_idx_reg, col_idx_next;
   logic [CNT_W-1:0]  settle_cnt_reg, settle_cnt_next;
   logic [N-1:0]      snapshot_reg, snapshot_next;
   logic [N-1:0]      prev_frame_reg, prev_frame_next;
   logic [N-1:0]      deb_frame_reg, deb_frame_next;
   logic [STB_W-1:0]  stable_cnt_reg, stable_cnt_next;
   logic [COLS-1:0]   col_out_next;
   logic              key_valid_next, key_pressed_next, overflow_next;
   logic [CODE_W-1:0] key_code_next;
   logic [N-1:0]      snap_sampled;
   logic [CODE_W-1:0] snap_code;
   logic              snap_onehot, commit, evt, drop;

   // Snapshot with the current column's bits replaced by the synchronized rows.
   for (genvar gr = 0; gr < ROWS; gr++) begin : g_row
      for (genvar gc = 0; gc < COLS; gc++) begin : g_col
         assign snap_sampled[gr*COLS + gc] = (col_idx_reg == COL_W'(gc)) ?
                                             rows_sync_reg[gr] : snapshot_reg[gr*COLS + gc];
      end
   end

   assign snap_onehot = (snapshot_reg != '0) &&
                        ((snapshot_reg & (snapshot_reg - N'(1))) == '0);

   always_comb begin
      snap_code = '0;
      for (int i = 0; i < N; i++) begin
         if (snapshot_reg[i]) snap_code = CODE_W'(i);
      end
   end

   always_comb begin
      state_next       = state_reg;
      col_idx_next     = col_idx_reg;
      settle_cnt_next  = settle_cnt_reg;
      snapshot_next    = snapshot_reg;
      prev_frame_next  = prev_frame_reg;
      deb_frame_next   = deb_frame_reg;
      stable_cnt_next  = stable_cnt_reg;
      key_pressed_next = key_pressed;
      key_valid_next   = key_valid;
      key_code_next    = key_code;
      commit           = 1'b0;
      evt              = 1'b0;
      drop             = 1'b0;

      case (state_reg)
         SETTLE: begin
            if (settle_cnt_reg == CNT_W'(SETTLE_CYC - 1)) begin
               settle_cnt_next = '0;
               snapshot_next   = snap_sampled;
               if (col_idx_reg == COL_W'(COLS - 1)) state_next = EVAL;
               else col_idx_next = col_idx_reg + 1'b1;
            end else begin
               settle_cnt_next = settle_cnt_reg + 1'b1;
            end
         end
         EVAL: begin
            if (snapshot_reg == prev_frame_reg) begin
               if (stable_cnt_reg != STB_W'(DEBOUNCE_SCANS))
                  stable_cnt_next = stable_cnt_reg + 1'b1;
               commit = (stable_cnt_reg == STB_W'(DEBOUNCE_SCANS - 1));
            end else begin
               stable_cnt_next = '0;
            end
            prev_frame_next = snapshot_reg;
            if (commit) begin
               deb_frame_next   = snapshot_reg;
               key_pressed_next = |snapshot_reg;
               evt              = snap_onehot && (snapshot_reg != deb_frame_reg);
            end
            col_idx_next = '0;
            state_next   = SETTLE;
         end
         default: state_next = SETTLE;
      endcase

      // Output buffer: a pending unconsumed code is never overwritten.
      if (evt && (!key_valid || key_ready)) begin
         key_code_next  = snap_code;
         key_valid_next = 1'b1;
      end else if (evt) begin
         drop = 1'b1;
      end else if (key_valid && key_ready) begin
         key_valid_next = 1'b0;
      end
      overflow_next = drop ? 1'b1 : (clear_ovf ? 1'b0 : overflow);

      // Column drive follows the next column index so it is valid for the whole settle window.
      col_out_next = (state_next == SETTLE) ? (COLS'(1) << col_idx_next) : '0;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg      <= SETTLE;
         rows_meta_reg  <= '0;
         rows_sync_reg  <= '0;
         col_idx_reg    <= '0;
         settle_cnt_reg <= '0;
         snapshot_reg   <= '0;
         prev_frame_reg <= '0;
         deb_frame_reg  <= '0;
         stable_cnt_reg <= '0;
         col_out        <= '0;
         key_valid      <= 1'b0;
         key_code       <= '0;
         key_pressed    <= 1'b0;
         overflow       <= 1'b0;
      end else begin
         state_reg      <= state_next;
         rows_meta_reg  <= rows_in;
         rows_sync_reg  <= rows_meta_reg;
         col_idx_reg    <= col_idx_next;
         settle_cnt_reg <= settle_cnt_next;
         snapshot_reg   <= snapshot_next;
         prev_frame_reg <= prev_frame_next;
         deb_frame_reg  <= deb_frame_next;
         stable_cnt_reg <= stable_cnt_next;
         col_out        <= col_out_next;
         key_valid      <= key_valid_next;
         key_code       <= key_code_next;
         key_pressed    <= key_pressed_next;
         overflow       <= overflow_next;
      end
   end

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Bench for keypad_scan_ctrl: a behavioural switch matrix drives rows_in from col_out;
// expected key codes are queued when keys are pressed and checked at each handshake.
module tb_keypad_scan_ctrl;

   localparam int FRAME = 4 * 8 + 1;
   localparam int WAITF = 6;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [3:0]  rows_in;
   logic [3:0]  col_out;
   logic        key_valid;
   logic [3:0]  key_code;
   logic        key_ready = 1'b0;
   logic        key_pressed;
   logic        overflow;
   logic        clear_ovf = 1'b0;
   logic [15:0] keys = '0;

   int n_cmp = 0;
   int n_bad = 0;
   int exp_q[$];

   keypad_scan_ctrl dut (
      .clk(clk), .reset(reset), .rows_in(rows_in), .col_out(col_out),
      .key_valid(key_valid), .key_code(key_code), .key_ready(key_ready),
      .key_pressed(key_pressed), .overflow(overflow), .clear_ovf(clear_ovf)
   );

   always #5 clk = ~clk;

   // Switch matrix: a closed key connects its column drive to its row line.
   always_comb begin
      rows_in = '0;
      for (int r = 0; r < 4; r++) rows_in[r] = |(col_out & keys[r*4 +: 4]);
   end

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end else begin
         $display("ok   %s: %0d", name, act);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Scoreboard: every handshake must match the oldest queued press; a held code must not move.
   logic       hold_prev = 1'b0;
   logic [3:0] code_prev = '0;
   always @(negedge clk) begin
      if (!reset && hold_prev) check("code_stable_while_held", key_code, code_prev);
      if (!reset && key_valid && key_ready) begin
         if (exp_q.size() == 0) check("unexpected_event_code", key_code, -1);
         else check("event_code", key_code, exp_q.pop_front());
      end
      hold_prev = !reset && key_valid && !key_ready;
      code_prev = key_code;
   end

   // Counts cycles from reset release to the first key_valid; also reports col_out after edge 1.
   task automatic measure_rise(output int rise, output int first_col);
      rise = -1;
      first_col = -1;
      for (int i = 1; i <= 400 && rise < 0; i++) begin
         tick(1);
         if (i == 1) first_col = col_out;
         if (key_valid) rise = i;
      end
   endtask

   typedef struct {
      logic [15:0] keys;
      bit          ev;
      int          code;
      bit          pressed;
   } vec_t;

   vec_t vecs[11];
   int   rise, first_col, seen;

   initial begin
      vecs[0]  = '{16'h0010, 1'b1,  4, 1'b1};
      vecs[1]  = '{16'h0000, 1'b0,  0, 1'b0};
      vecs[2]  = '{16'h1000, 1'b1, 12, 1'b1};
      vecs[3]  = '{16'h0000, 1'b0,  0, 1'b0};
      vecs[4]  = '{16'h0021, 1'b0,  0, 1'b1};
      vecs[5]  = '{16'h0001, 1'b1,  0, 1'b1};
      vecs[6]  = '{16'h0001, 1'b0,  0, 1'b1};
      vecs[7]  = '{16'h8000, 1'b1, 15, 1'b1};
      vecs[8]  = '{16'h8001, 1'b0,  0, 1'b1};
      vecs[9]  = '{16'h8000, 1'b1, 15, 1'b1};
      vecs[10] = '{16'h0000, 1'b0,  0, 1'b0};

      // Reset values, then a single press of key 9 held since before the first frame.
      keys = 16'h0200;
      tick(3);
      check("rst_col_out", col_out, 0);
      check("rst_key_valid", key_valid, 0);
      check("rst_key_code", key_code, 0);
      check("rst_key_pressed", key_pressed, 0);
      check("rst_overflow", overflow, 0);
      exp_q.push_back(9);
      reset = 1'b0;
      measure_rise(rise, first_col);
      check("first_col_out", first_col, 1);
      check("press_latency", rise, 5 * FRAME);
      check("press_code", key_code, 9);
      check("press_pressed", key_pressed, 1);
      key_ready = 1'b1;
      tick(1);
      key_ready = 1'b0;
      check("valid_after_ready", key_valid, 0);
      tick(10 * FRAME);
      check("held_no_repeat", key_valid, 0);
      keys = '0;
      tick(WAITF * FRAME);
      check("release_pressed", key_pressed, 0);

      // Table: press/release, ghost frames and single-key returns with key_ready tied high.
      key_ready = 1'b1;
      for (int v = 0; v < 11; v++) begin
         keys = vecs[v].keys;
         if (vecs[v].ev) exp_q.push_back(vecs[v].code);
         tick(WAITF * FRAME);
         check($sformatf("vec%0d_pressed", v), key_pressed, vecs[v].pressed);
         check($sformatf("vec%0d_pending", v), exp_q.size(), 0);
         check($sformatf("vec%0d_overflow", v), overflow, 0);
      end

      // Bounce: toggling faster than the debounce window never commits a press.
      seen = 0;
      for (int t = 0; t < 15; t++) begin
         keys = keys ^ 16'h0200;
         for (int c = 0; c < 20; c++) begin
            tick(1);
            if (key_pressed) seen = 1;
         end
      end
      keys = '0;
      tick(WAITF * FRAME);
      check("bounce_pressed_seen", seen, 0);
      check("bounce_valid", key_valid, 0);

      // Overflow: a second press while the first is unconsumed is dropped.
      key_ready = 1'b0;
      keys = 16'h0008;
      exp_q.push_back(3);
      tick(WAITF * FRAME);
      check("ovf_first_valid", key_valid, 1);
      check("ovf_first_code", key_code, 3);
      keys = '0;
      tick(WAITF * FRAME);
      keys = 16'h0080;
      tick(WAITF * FRAME);
      check("ovf_code_kept", key_code, 3);
      check("ovf_flag", overflow, 1);
      check("ovf_valid_kept", key_valid, 1);
      clear_ovf = 1'b1;
      tick(1);
      clear_ovf = 1'b0;
      check("ovf_cleared", overflow, 0);
      key_ready = 1'b1;
      tick(1);
      key_ready = 1'b0;
      check("ovf_valid_drop", key_valid, 0);
      keys = '0;
      tick(WAITF * FRAME);
      check("ovf_after_release", overflow, 0);
      check("ovf_pending", exp_q.size(), 0);

      // Reset during column 2 with key 6 held: restart and full debounce latency.
      keys = 16'h0040;
      for (int i = 0; i < 2 * FRAME && col_out != 4'b0100; i++) tick(1);
      check("reached_col2", col_out, 4);
      tick(3);
      #2 reset = 1'b1;
      #1;
      check("midrst_col_out", col_out, 0);
      check("midrst_valid", key_valid, 0);
      check("midrst_pressed", key_pressed, 0);
      check("midrst_overflow", overflow, 0);
      tick(3);
      exp_q.push_back(6);
      reset = 1'b0;
      measure_rise(rise, first_col);
      check("midrst_first_col", first_col, 1);
      check("midrst_latency", rise, 5 * FRAME);
      check("midrst_code", key_code, 6);
      key_ready = 1'b1;
      tick(1);
      key_ready = 1'b0;
      tick(1);
      check("final_pending", exp_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
